// File: rtl/serial_frame_rx.sv
// Bit-serial frame receiver: start bit, DATA_W data bits LSB-first, stop bit; one bit per clock.
// Good words land in a single holding register behind a valid/ready handshake; framing errors and overruns pulse for one cycle.
module serial_frame_rx #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              din,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              frame_err,
    output logic              overrun
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  shreg_q, shreg_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]  dout_q, dout_d;
    logic               dout_valid_q, dout_valid_d;
    logic               frame_err_q, frame_err_d;
    logic               overrun_q, overrun_d;
    logic               hold_free;

    // The holding register can take a new word on the same edge the old one is consumed.
    assign hold_free = !dout_valid_q || dout_ready;

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        bit_cnt_d    = bit_cnt_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        frame_err_d  = 1'b0;
        overrun_d    = 1'b0;

        if (dout_valid_q && dout_ready) begin
            dout_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (!din) begin
                    state_d   = S_DATA;
                    bit_cnt_d = '0;
                end
            end
            S_DATA: begin
                shreg_d[DATA_W-1] = din;
                for (int i = 0; i < DATA_W - 1; i++) begin
                    shreg_d[i] = shreg_q[i+1];
                end
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
                if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (din) begin
                    if (hold_free) begin
                        dout_d       = shreg_q;
                        dout_valid_d = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end else begin
                    frame_err_d = 1'b1;
                    state_d     = S_BREAK;
                end
            end
            S_BREAK: begin
                // A held-low line must return high before another start bit counts.
                if (din) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Scoreboard bench for serial_frame_rx: the driver predicts words and pulses with their edge numbers,
// a negedge monitor pops and compares whatever the receiver presents.
module tb_serial_frame_rx;

    logic       clk;
    logic       rst_n;
    logic       din;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready;
    logic       frame_err;
    logic       overrun;

    serial_frame_rx #(.DATA_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .dout      (dout),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    typedef struct {
        logic [7:0] data;
        int         edge_n;
    } exp_t;

    exp_t wq[$];
    int   eq[$];
    int   oq[$];

    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    int   rdy_mode = 1;     // 0: never ready, 1: always ready, 2: random
    logic held   = 1'b0;    // model: holding register occupied

    logic       prev_valid = 1'b0;
    logic       prev_hs    = 1'b0;
    logic [7:0] prev_dout  = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (edge %0d)", name, got, want, cyc);
        end
    endtask

    function automatic logic pick_ready();
        if (rdy_mode == 0) return 1'b0;
        if (rdy_mode == 1) return 1'b1;
        return ($urandom_range(0, 99) < 60);
    endfunction

    // kind: 0 ordinary bit, 1 good stop bit, 2 bad stop bit
    task automatic send_bit(input logic b, input int kind, input logic [7:0] data, input logic r);
        exp_t e;
        int   edge_n;
        @(posedge clk);
        #1;
        din        = b;
        dout_ready = r;
        edge_n     = cyc + 1;
        if (kind == 1) begin
            if (!held || r) begin
                e.data   = data;
                e.edge_n = edge_n;
                wq.push_back(e);
                held = 1'b1;
            end else begin
                oq.push_back(edge_n);
            end
        end else begin
            if (kind == 2) eq.push_back(edge_n);
            if (held && r) held = 1'b0;
        end
    endtask

    // stop_rdy: 0/1 forces ready on the stop edge, 2 follows rdy_mode
    task automatic send_frame(input logic [7:0] data, input logic stop_ok, input int stop_rdy);
        logic r;
        send_bit(1'b0, 0, 8'h00, pick_ready());
        for (int i = 0; i < 8; i++) send_bit(data[i], 0, 8'h00, pick_ready());
        r = (stop_rdy == 2) ? pick_ready() : (stop_rdy == 1);
        send_bit(stop_ok, stop_ok ? 1 : 2, data, r);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b1, 0, 8'h00, pick_ready());
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_dout"},  {24'd0, dout}, 32'd0);
        check({tag, "_valid"}, {31'd0, dout_valid}, 32'd0);
        check({tag, "_ferr"},  {31'd0, frame_err}, 32'd0);
        check({tag, "_ovr"},   {31'd0, overrun}, 32'd0);
    endtask

    // Monitor: a word is "fresh" when valid appears or persists right after a handshake.
    always @(negedge clk) begin
        exp_t e;
        int   p;
        if (!rst_n) begin
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
        end else begin
            if (prev_valid && !prev_hs) begin
                check("hold_valid", {31'd0, dout_valid}, 32'd1);
                check("hold_dout", {24'd0, dout}, {24'd0, prev_dout});
            end else if (dout_valid) begin
                if (wq.size() == 0) begin
                    check("word_unexpected", {24'd0, dout}, 32'hFFFF_FFFF);
                end else begin
                    e = wq.pop_front();
                    check("word_data", {24'd0, dout}, {24'd0, e.data});
                    check("word_edge", cyc, e.edge_n);
                end
            end
            if (frame_err) begin
                p = (eq.size() == 0) ? -1 : eq.pop_front();
                check("frame_err_edge", cyc, p);
            end
            if (overrun) begin
                p = (oq.size() == 0) ? -1 : oq.pop_front();
                check("overrun_edge", cyc, p);
            end
            prev_valid = dout_valid;
            prev_hs    = dout_valid && dout_ready;
            prev_dout  = dout;
        end
    end

    initial begin
        logic [7:0] w;
        logic       ok;
        rst_n      = 1'b0;
        din        = 1'b1;
        dout_ready = 1'b0;
        #1;
        check_reset_outputs("reset");
        #20;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        // single frame
        rdy_mode = 1;
        send_frame(8'hA5, 1'b1, 2);
        idle(3);

        // back-to-back
        send_frame(8'h3C, 1'b1, 2);
        send_frame(8'hFF, 1'b1, 2);
        idle(2);

        // bad stop, held-low line, then recovery
        send_frame(8'h55, 1'b0, 2);
        for (int i = 0; i < 5; i++) send_bit(1'b0, 0, 8'h00, 1'b1);
        idle(1);
        send_frame(8'h12, 1'b1, 2);
        idle(2);

        // overrun with downstream stalled
        rdy_mode = 0;
        send_frame(8'h01, 1'b1, 2);
        send_frame(8'h02, 1'b1, 2);
        idle(2);
        send_bit(1'b1, 0, 8'h00, 1'b1);
        idle(2);

        // accept and load on the same edge
        send_frame(8'h10, 1'b1, 2);
        idle(1);
        send_frame(8'h20, 1'b1, 1);
        idle(1);
        send_bit(1'b1, 0, 8'h00, 1'b1);
        idle(1);

        // reset mid-frame while a word is held
        send_frame(8'h5A, 1'b1, 2);
        w = 8'h77;
        send_bit(1'b0, 0, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(w[i], 0, 8'h00, 1'b0);
        @(posedge clk);
        #1;
        din   = w[4];
        rst_n = 1'b0;
        held  = 1'b0;
        #1;
        check_reset_outputs("midreset");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        din   = 1'b1;
        rdy_mode = 1;
        idle(1);
        send_frame(8'h81, 1'b1, 2);
        idle(2);

        // randomized traffic
        rdy_mode = 2;
        for (int n = 0; n < 150; n++) begin
            w  = 8'($urandom);
            ok = ($urandom_range(0, 9) != 0);
            send_frame(w, ok, 2);
            if (ok) begin
                idle($urandom_range(0, 2));
            end else begin
                for (int i = 0; i < int'($urandom_range(0, 4)); i++) send_bit(1'b0, 0, 8'h00, pick_ready());
                idle($urandom_range(1, 3));
            end
        end

        rdy_mode = 1;
        idle(12);
        check("words_left", wq.size(), 0);
        check("ferr_left", eq.size(), 0);
        check("ovr_left", oq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
